round_sched: RTL and testbench

Iterative round scheduler for the non-linear transform datapath. It accepts one block with a valid/ready handshake and holds the cipher state in a register. Each round it fetches a round key from an external key store, drives the datapath's key, state, mode and algorithm inputs, and captures the datapath's NTO result back into the state. It sits between the block-level I/O and the combinational round datapath.

---
 rtl/round_sched_pkg.sv | 6 +
 rtl/round_sched_if.sv | 37 +++
 rtl/round_sched_rk_index_gen.sv | 12 +
 rtl/round_sched.sv | 86 ++++++++
 tb/tb_round_sched.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/round_sched_pkg.sv
// round_sched_pkg: shared FSM states, constants and default widths for round_sched
package round_sched_pkg;
  localparam int ROUND_W_DEF = 6;
  localparam logic [2:0] ALG_FINAL = 3'b000;
  typedef enum logic [2:0] {IDLE, KREQ, ROUND, WHT, DONE} state_t;
endpackage

// File: rtl/round_sched_if.sv
// round_sched_if: block I/O, key-store and datapath signals of round_sched
// slave = scheduler side; master = environment (source/sink, key store, datapath)
interface round_sched_if
  import round_sched_pkg::*;
#(parameter int N = 128, parameter int ROUND_W = ROUND_W_DEF);
  logic               in_valid;
  logic               in_ready;
  logic [N-1:0]       in_data;
  logic               in_mode_enc_dec;
  logic [2:0]         in_alg_mode;
  logic [ROUND_W-1:0] in_rounds;
  logic               rk_req;
  logic [ROUND_W-1:0] rk_idx;
  logic               rk_valid;
  logic [N-1:0]       rk_data;
  logic [N-1:0]       dp_rki;
  logic [N-1:0]       dp_rec;
  logic               dp_mode_enc_dec;
  logic [2:0]         dp_alg_mode;
  logic [N-1:0]       dp_nto;
  logic               out_valid;
  logic               out_ready;
  logic [N-1:0]       out_data;
  logic               busy;
  modport slave (
    input  in_valid, in_data, in_mode_enc_dec, in_alg_mode, in_rounds,
    input  rk_valid, rk_data, dp_nto, out_ready,
    output in_ready, rk_req, rk_idx, dp_rki, dp_rec, dp_mode_enc_dec, dp_alg_mode,
    output out_valid, out_data, busy
  );
  modport master (
    output in_valid, in_data, in_mode_enc_dec, in_alg_mode, in_rounds,
    output rk_valid, rk_data, dp_nto, out_ready,
    input  in_ready, rk_req, rk_idx, dp_rki, dp_rec, dp_mode_enc_dec, dp_alg_mode,
    input  out_valid, out_data, busy
  );
endinterface

// File: rtl/round_sched_rk_index_gen.sv
// rk_index_gen: maps (mode, round r, round count R, whitening) to the key-store index
// i_mode 0=encrypt 1=decrypt; i_r current round; i_rounds R; i_wht final whitening fetch; o_idx key index
module rk_index_gen #(parameter int ROUND_W = 6) (
  input  logic               i_mode,
  input  logic [ROUND_W-1:0] i_r,
  input  logic [ROUND_W-1:0] i_rounds,
  input  logic               i_wht,
  output logic [ROUND_W-1:0] o_idx
);
  assign o_idx = i_wht ? (i_mode ? '0 : i_rounds)
                       : (i_mode ? i_rounds - i_r + ROUND_W'(1) : i_r - ROUND_W'(1));
endmodule

// File: rtl/round_sched.sv
// round_sched: iterative round scheduler driving a combinational round datapath
// clk/rst: clock, async active-high reset; io: round_sched_if.slave (block in/out,
// key-store request/grant, datapath drive/result, busy). Macro ROUND_SCHED_ZEROIZE_EN
// clears state and key on the output handshake.
module round_sched
  import round_sched_pkg::*;
#(parameter int N = 128, parameter int ROUND_W = ROUND_W_DEF) (
  input logic clk,
  input logic rst,
  round_sched_if.slave io
);
`ifdef ROUND_SCHED_ZEROIZE_EN
  localparam bit ZEROIZE = 1'b1;
`else
  localparam bit ZEROIZE = 1'b0;
`endif
  state_t             r_state, w_next;
  logic [N-1:0]       r_data, r_key;
  logic               r_mode;
  logic [2:0]         r_alg;
  logic [ROUND_W-1:0] r_rounds;
  // one extra bit: r reaches R+1 = 2^ROUND_W when R is at its maximum
  logic [ROUND_W:0]   r_r;
  logic               w_wht, w_kreq, w_pre_final;
  logic [ROUND_W-1:0] w_idx;
  assign w_wht       = r_r > {1'b0, r_rounds};
  assign w_pre_final = r_r < {1'b0, r_rounds};
  assign w_kreq      = r_state == KREQ;
  rk_index_gen #(.ROUND_W(ROUND_W)) u_idx (
    .i_mode(r_mode), .i_r(r_r[ROUND_W-1:0]), .i_rounds(r_rounds), .i_wht(w_wht), .o_idx(w_idx)
  );
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = io.in_valid ? KREQ : IDLE;
      KREQ:    w_next = io.rk_valid ? (w_wht ? WHT : ROUND) : KREQ;
      ROUND:   w_next = KREQ;
      WHT:     w_next = DONE;
      DONE:    w_next = io.out_ready ? IDLE : DONE;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state  <= IDLE;
      r_data   <= '0;
      r_key    <= '0;
      r_mode   <= 1'b0;
      r_alg    <= '0;
      r_rounds <= '0;
      r_r      <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: if (io.in_valid) begin
          r_data   <= io.in_data;
          r_mode   <= io.in_mode_enc_dec;
          r_alg    <= io.in_alg_mode;
          r_rounds <= (io.in_rounds == '0) ? ROUND_W'(1) : io.in_rounds;
          r_r      <= (ROUND_W+1)'(1);
        end
        KREQ:  if (io.rk_valid) r_key <= io.rk_data;
        ROUND: begin
          r_data <= io.dp_nto;
          r_r    <= r_r + (ROUND_W+1)'(1);
        end
        WHT:   r_data <= r_data ^ r_key;
        DONE:  if (ZEROIZE && io.out_ready) begin
          r_data <= '0;
          r_key  <= '0;
        end
        default: ;
      endcase
    end
  assign io.in_ready        = r_state == IDLE;
  assign io.busy            = r_state != IDLE;
  assign io.rk_req          = w_kreq;
  // index forced to 0 outside a request so it reads 0 from reset
  assign io.rk_idx          = w_kreq ? w_idx : '0;
  assign io.dp_rki          = r_key;
  assign io.dp_rec          = r_data;
  assign io.dp_mode_enc_dec = r_mode;
  assign io.dp_alg_mode     = w_pre_final ? r_alg : ALG_FINAL;
  assign io.out_valid       = r_state == DONE;
  assign io.out_data        = (r_state == DONE) ? r_data : '0;
endmodule

// File: tb/tb_round_sched.sv
// tb_round_sched: directed self-checking bench for round_sched with a +1 stub datapath
module tb_round_sched;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int vecs = 0;
  int errs = 0;
  round_sched_if #(.N(128), .ROUND_W(6)) bus ();
  round_sched #(.N(128), .ROUND_W(6)) dut (.clk(clk), .rst(rst), .io(bus));
  always #5 clk = ~clk;
  assign bus.dp_nto = bus.dp_rec + 128'd1;

  // key store content: every nibble of key i is (i+1) mod 16
  function automatic logic [127:0] key(input logic [5:0] i);
    logic [3:0] n;
    n = 4'(i + 6'd1);
    return {32{n}};
  endfunction

  function automatic logic [5:0] exp_idx(input logic mode, input int g, input int r);
    return mode ? 6'(r - g + 1) : 6'(g - 1);
  endfunction

  task automatic test_reset(input string nm);
    #2 rst = 1'b1;
    #1;
    vecs++; if ({bus.in_ready, bus.busy, bus.rk_req, bus.out_valid, bus.dp_mode_enc_dec} !== 5'b10000) begin
      errs++; $display("FAIL %s ctrl {in_ready,busy,rk_req,out_valid,dp_mode}: got %b want 10000", nm,
        {bus.in_ready, bus.busy, bus.rk_req, bus.out_valid, bus.dp_mode_enc_dec});
    end
    vecs++; if (bus.rk_idx !== 6'd0) begin errs++; $display("FAIL %s rk_idx: got %0d want 0", nm, bus.rk_idx); end
    vecs++; if (bus.out_data !== 128'd0) begin errs++; $display("FAIL %s out_data: got %h want 0", nm, bus.out_data); end
    vecs++; if (bus.dp_rki !== 128'd0) begin errs++; $display("FAIL %s dp_rki: got %h want 0", nm, bus.dp_rki); end
    vecs++; if (bus.dp_rec !== 128'd0) begin errs++; $display("FAIL %s dp_rec: got %h want 0", nm, bus.dp_rec); end
    vecs++; if (bus.dp_alg_mode !== 3'b000) begin errs++; $display("FAIL %s dp_alg_mode: got %b want 000", nm, bus.dp_alg_mode); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Applies one block and follows it to the output handshake, checking each key
  // request, each ROUND cycle, latency, result and post-handshake state.
  task automatic run_block(input string nm, input logic mode, input logic [2:0] alg,
                           input logic [5:0] rounds, input logic [127:0] din,
                           input logic [127:0] exp_out, input int stall_max, input int hold);
    int r, g, stall, total;
    bit done, in_req, round_next;
    logic [5:0] held;
    r = (rounds == 6'd0) ? 1 : int'(rounds);
    g = 0; stall = 0; total = 0; done = 0; in_req = 0; round_next = 0; held = '0;
    @(negedge clk);
    vecs++; if (bus.in_ready !== 1'b1) begin errs++; $display("FAIL %s in_ready before accept: got %b want 1", nm, bus.in_ready); end
    bus.in_valid = 1'b1; bus.in_data = din; bus.in_mode_enc_dec = mode;
    bus.in_alg_mode = alg; bus.in_rounds = rounds; bus.out_ready = 1'b0;
    bus.rk_valid = (stall_max == 0); bus.rk_data = '1;
    @(posedge clk);
    for (int c = 1; c <= 600 && !done; c++) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in_data = '1;
      if (round_next) begin
        round_next = 0;
        vecs++; if (bus.dp_alg_mode !== ((g < r) ? alg : 3'b000)) begin
          errs++; $display("FAIL %s round %0d dp_alg_mode: got %b want %b", nm, g, bus.dp_alg_mode, (g < r) ? alg : 3'b000);
        end
        vecs++; if (bus.dp_rki !== key(exp_idx(mode, g, r))) begin
          errs++; $display("FAIL %s round %0d dp_rki: got %h want %h", nm, g, bus.dp_rki, key(exp_idx(mode, g, r)));
        end
        vecs++; if (bus.dp_rec !== din + 128'(g - 1)) begin
          errs++; $display("FAIL %s round %0d dp_rec: got %h want %h", nm, g, bus.dp_rec, din + 128'(g - 1));
        end
      end
      if (bus.out_valid) begin
        done = 1;
        bus.rk_valid = 1'b0;
        vecs++; if (c !== 2 * r + 3 + total) begin
          errs++; $display("FAIL %s latency: got %0d want %0d", nm, c, 2 * r + 3 + total);
        end
        vecs++; if (g !== r + 1) begin errs++; $display("FAIL %s key grants: got %0d want %0d", nm, g, r + 1); end
        vecs++; if (bus.out_data !== exp_out) begin errs++; $display("FAIL %s out_data: got %h want %h", nm, bus.out_data, exp_out); end
        for (int h = 0; h < hold; h++) begin
          @(negedge clk);
          vecs++; if ({bus.out_valid, bus.in_ready, bus.busy} !== 3'b101) begin
            errs++; $display("FAIL %s hold %0d {out_valid,in_ready,busy}: got %b want 101", nm, h, {bus.out_valid, bus.in_ready, bus.busy});
          end
          vecs++; if (bus.out_data !== exp_out) begin errs++; $display("FAIL %s hold %0d out_data: got %h want %h", nm, h, bus.out_data, exp_out); end
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        vecs++; if ({bus.out_valid, bus.in_ready, bus.busy} !== 3'b010) begin
          errs++; $display("FAIL %s after handshake {out_valid,in_ready,busy}: got %b want 010", nm, {bus.out_valid, bus.in_ready, bus.busy});
        end
`ifdef ROUND_SCHED_ZEROIZE_EN
        vecs++; if (bus.dp_rec !== 128'd0 || bus.dp_rki !== 128'd0) begin
          errs++; $display("FAIL %s zeroize dp_rec/dp_rki: got %h/%h want 0/0", nm, bus.dp_rec, bus.dp_rki);
        end
`else
        vecs++; if (bus.dp_rec !== exp_out) begin errs++; $display("FAIL %s retained dp_rec: got %h want %h", nm, bus.dp_rec, exp_out); end
`endif
      end else if (bus.rk_req) begin
        if (!in_req) begin
          in_req = 1;
          held = bus.rk_idx;
          stall = (stall_max == 0) ? 0 : int'($urandom_range(0, stall_max));
          total += stall;
          vecs++; if (bus.rk_idx !== exp_idx(mode, g + 1, r)) begin
            errs++; $display("FAIL %s request %0d rk_idx: got %0d want %0d", nm, g + 1, bus.rk_idx, exp_idx(mode, g + 1, r));
          end
        end else begin
          vecs++; if (bus.rk_idx !== held) begin errs++; $display("FAIL %s rk_idx unstable: got %0d want %0d", nm, bus.rk_idx, held); end
        end
        if (stall == 0) begin
          bus.rk_valid = 1'b1;
          bus.rk_data = key(bus.rk_idx);
          g++;
          in_req = 0;
          round_next = (g <= r);
        end else begin
          stall--;
          bus.rk_valid = 1'b0;
          bus.rk_data = {4{32'hDEADBEEF}};
        end
      end else begin
        bus.rk_valid = (stall_max == 0);
        bus.rk_data = '1;
      end
    end
    if (!done) begin errs++; vecs++; $display("FAIL %s timeout: out_valid got 0 want 1", nm); end
  endtask

  task automatic test_encrypt();
    run_block("enc_r4", 1'b0, 3'b101, 6'd4, 128'h1000,
              128'h5555_5555_5555_5555_5555_5555_5555_4551, 0, 0);
  endtask

  task automatic test_decrypt();
    run_block("dec_r4", 1'b1, 3'b011, 6'd4, 128'h1000,
              128'h1111_1111_1111_1111_1111_1111_1111_0115, 0, 0);
  endtask

  task automatic test_stall();
    run_block("enc_stall", 1'b0, 3'b101, 6'd4, 128'h1000,
              128'h5555_5555_5555_5555_5555_5555_5555_4551, 5, 0);
    run_block("dec_stall", 1'b1, 3'b011, 6'd4, 128'h1000,
              128'h1111_1111_1111_1111_1111_1111_1111_0115, 5, 0);
  endtask

  task automatic test_zero_rounds();
    run_block("r0", 1'b0, 3'b110, 6'd0, 128'h1000,
              128'h2222_2222_2222_2222_2222_2222_2222_3223, 0, 0);
  endtask

  task automatic test_out_hold();
    run_block("hold10", 1'b0, 3'b111, 6'd2, 128'hF0,
              128'h3333_3333_3333_3333_3333_3333_3333_33C1, 0, 10);
  endtask

  task automatic test_max_rounds();
    run_block("enc_r63", 1'b0, 3'b001, 6'd63, 128'h0, 128'h3F, 0, 0);
    run_block("dec_r63", 1'b1, 3'b001, 6'd63, 128'h0,
              128'h1111_1111_1111_1111_1111_1111_1111_112E, 0, 0);
  endtask

  task automatic test_back_to_back();
    run_block("b2b_a", 1'b1, 3'b010, 6'd4, 128'h1000,
              128'h1111_1111_1111_1111_1111_1111_1111_0115, 0, 0);
    run_block("b2b_b", 1'b0, 3'b010, 6'd0, 128'h1000,
              128'h2222_2222_2222_2222_2222_2222_2222_3223, 0, 0);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_data = 128'h77; bus.in_mode_enc_dec = 1'b1;
    bus.in_alg_mode = 3'b101; bus.in_rounds = 6'd4; bus.rk_valid = 1'b1; bus.rk_data = key(6'd9);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (4) @(negedge clk);
    vecs++; if (bus.busy !== 1'b1) begin errs++; $display("FAIL mid_rst busy before reset: got %b want 1", bus.busy); end
    test_reset("mid_rst");
    run_block("after_rst", 1'b0, 3'b101, 6'd4, 128'h1000,
              128'h5555_5555_5555_5555_5555_5555_5555_4551, 0, 0);
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_mode_enc_dec = 1'b0; bus.in_alg_mode = '0;
    bus.in_rounds = '0; bus.rk_valid = 1'b0; bus.rk_data = '0; bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    test_reset("reset");
    test_encrypt();
    test_decrypt();
    test_stall();
    test_zero_rounds();
    test_out_hold();
    test_max_rounds();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
